// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and constants for the fetch stage
package fetch_stage_pkg;

   typedef enum logic [2:0] {
      ST_RST_HI = 3'd0,
      ST_RST_LO = 3'd1,
      ST_RUN    = 3'd2,
      ST_INT_HI = 3'd3,
      ST_INT_LO = 3'd4
   } fetch_state_t;

   typedef enum logic [2:0] {
      PC_HOLD    = 3'd0,
      PC_INC     = 3'd1,
      PC_LOAD    = 3'd2,
      PC_LOAD_HI = 3'd3,
      PC_LOAD_LO = 3'd4
   } pc_op_t;

   localparam logic [15:0] NOP_INSTR       = 16'h0000;
   localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_0000;
   localparam logic [31:0] DEF_INT_VEC     = 32'h0000_0002;

endpackage

// File: rtl/fetch_stage_pc_register.sv
// rtl/fetch_stage_pc_register.sv - program counter with hold, increment, full and half-word load
module pc_register
   import fetch_stage_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_resetn,
   input  pc_op_t      i_op,
   input  logic [31:0] i_load,
   input  logic [15:0] i_half,
   output logic [31:0] o_pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      case (i_op)
         PC_INC:     pc_d = pc_q + 32'd1;
         PC_LOAD:    pc_d = i_load;
         PC_LOAD_HI: pc_d = {i_half, pc_q[15:0]};
         PC_LOAD_LO: pc_d = {pc_q[31:16], i_half};
         default:    pc_d = pc_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) pc_q <= 32'h0000_0000;
      else           pc_q <= pc_d;
   end

   assign o_pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with vector loads, stall, redirect and interrupt tokens
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_VEC_ADDR = DEF_RESET_VEC,
   parameter logic [31:0] INT_VEC_ADDR   = DEF_INT_VEC
)(
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic [15:0] i_imem_data,
   input  logic        i_stall,
   input  logic        i_branch_taken,
   input  logic [31:0] i_branch_target,
   input  logic        i_interrupt,
   output logic [15:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_valid,
   output logic        o_interrupt
);

   fetch_state_t state_q, state_d;
   logic         pending_q, pending_d;
   logic [15:0]  instr_q, instr_d;
   logic [31:0]  opc_q, opc_d;
   logic         valid_q, valid_d;
   logic         intr_q, intr_d;
   pc_op_t       pc_op;
   logic [31:0]  pc;
   logic         done;

   pc_register u_pc (
      .i_clk    (i_clk),
      .i_resetn (i_reset),
      .i_op     (pc_op),
      .i_load   (i_branch_target),
      .i_half   (i_imem_data),
      .o_pc     (pc)
   );

   // A pending interrupt in RUN suppresses fetching so the token carries the un-advanced pc.
   assign o_imem_req = i_reset && !i_stall && !(state_q == ST_RUN && pending_q);
   assign done       = o_imem_req && i_imem_ready;

   always_comb begin
      case (state_q)
         ST_RST_HI: o_imem_addr = RESET_VEC_ADDR;
         ST_RST_LO: o_imem_addr = RESET_VEC_ADDR + 32'd1;
         ST_INT_HI: o_imem_addr = INT_VEC_ADDR;
         ST_INT_LO: o_imem_addr = INT_VEC_ADDR + 32'd1;
         default:   o_imem_addr = pc;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q || i_interrupt;
      instr_d   = instr_q;
      opc_d     = opc_q;
      valid_d   = valid_q;
      intr_d    = intr_q;
      pc_op     = PC_HOLD;
      if (i_branch_taken) begin
         pc_op   = PC_LOAD;
         valid_d = 1'b0;
         intr_d  = 1'b0;
      end else if (!i_stall) begin
         valid_d = 1'b0;
         intr_d  = 1'b0;
         case (state_q)
            ST_RST_HI, ST_INT_HI: if (done) begin
               pc_op   = PC_LOAD_HI;
               state_d = (state_q == ST_RST_HI) ? ST_RST_LO : ST_INT_LO;
            end
            ST_RST_LO, ST_INT_LO: if (done) begin
               pc_op   = PC_LOAD_LO;
               state_d = ST_RUN;
            end
            ST_RUN: if (pending_q) begin
               valid_d   = 1'b1;
               intr_d    = 1'b1;
               instr_d   = NOP_INSTR;
               opc_d     = pc;
               pending_d = i_interrupt;
               state_d   = ST_INT_HI;
            end else if (done) begin
               valid_d = 1'b1;
               instr_d = i_imem_data;
               opc_d   = pc;
               pc_op   = PC_INC;
            end
            default: state_d = ST_RST_HI;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q   <= ST_RST_HI;
         pending_q <= 1'b0;
         instr_q   <= NOP_INSTR;
         opc_q     <= 32'h0000_0000;
         valid_q   <= 1'b0;
         intr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         instr_q   <= instr_d;
         opc_q     <= opc_d;
         valid_q   <= valid_d;
         intr_q    <= intr_d;
      end
   end

   assign o_instr     = instr_q;
   assign o_pc        = opc_q;
   assign o_valid     = valid_q;
   assign o_interrupt = intr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready;
   logic [15:0] i_imem_data;
   logic        i_stall;
   logic        i_branch_taken;
   logic [31:0] i_branch_target;
   logic        i_interrupt;
   logic [15:0] o_instr;
   logic [31:0] o_pc;
   logic        o_valid;
   logic        o_interrupt;

   logic [15:0] imem [0:255];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign i_imem_data = imem[o_imem_addr[7:0]];

   fetch_stage dut (
      .i_clk           (clk),
      .i_reset         (i_reset),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_ready    (i_imem_ready),
      .i_imem_data     (i_imem_data),
      .i_stall         (i_stall),
      .i_branch_taken  (i_branch_taken),
      .i_branch_target (i_branch_target),
      .i_interrupt     (i_interrupt),
      .o_instr         (o_instr),
      .o_pc            (o_pc),
      .o_valid         (o_valid),
      .o_interrupt     (o_interrupt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic intr,
                          input logic [31:0] pc, input logic [15:0] instr);
      chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
      chk({tag, "_intr"},  {31'd0, o_interrupt}, {31'd0, intr});
      if (v) begin
         chk({tag, "_pc"},    o_pc, pc);
         chk({tag, "_instr"}, {16'd0, o_instr}, {16'd0, instr});
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) imem[a] = {8'hA5, a[7:0]};
      imem[0]    = 16'h0000;
      imem[1]    = 16'h0010;
      imem[2]    = 16'h0000;
      imem[3]    = 16'h0080;
      imem[8'h10] = 16'h1234;
      i_reset = 1'b0; i_imem_ready = 1'b1; i_stall = 1'b0;
      i_branch_taken = 1'b0; i_branch_target = 32'd0; i_interrupt = 1'b0;

      tick(); tick();
      chk("rst_req", {31'd0, o_imem_req}, 32'd0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_intr", {31'd0, o_interrupt}, 32'd0);
      chk("rst_instr", {16'd0, o_instr}, 32'd0);
      chk("rst_pc", o_pc, 32'd0);

      i_reset = 1'b1; settle();
      chk("boot_req", {31'd0, o_imem_req}, 32'd1);
      chk("boot_addr0", o_imem_addr, 32'd0);
      tick();
      chk("boot_addr1", o_imem_addr, 32'd1);
      chk("boot_bubble", {31'd0, o_valid}, 32'd0);
      tick();
      chk("run_addr", o_imem_addr, 32'h10);
      tick();
      chk_out("first", 1'b1, 1'b0, 32'h10, 16'h1234);
      tick();
      chk_out("second", 1'b1, 1'b0, 32'h11, 16'hA511);

      i_stall = 1'b1; settle();
      chk("stall_req", {31'd0, o_imem_req}, 32'd0);
      tick();
      chk_out("stall1", 1'b1, 1'b0, 32'h11, 16'hA511);
      tick();
      chk_out("stall2", 1'b1, 1'b0, 32'h11, 16'hA511);
      i_stall = 1'b0;
      tick();
      chk_out("post_stall", 1'b1, 1'b0, 32'h12, 16'hA512);

      chk("br_addr", o_imem_addr, 32'h13);
      i_branch_taken = 1'b1; i_branch_target = 32'h40;
      tick();
      i_branch_taken = 1'b0;
      chk_out("br_bubble", 1'b0, 1'b0, 32'h0, 16'h0);
      tick();
      chk_out("br_target", 1'b1, 1'b0, 32'h40, 16'hA540);

      i_branch_taken = 1'b1; i_branch_target = 32'h20; i_interrupt = 1'b1;
      tick();
      i_branch_taken = 1'b0; i_interrupt = 1'b0; settle();
      chk_out("brint_bubble", 1'b0, 1'b0, 32'h0, 16'h0);
      chk("int_noreq", {31'd0, o_imem_req}, 32'd0);
      tick();
      chk_out("token", 1'b1, 1'b1, 32'h20, 16'h0000);
      chk("ivec_hi", o_imem_addr, 32'd2);
      tick();
      chk_out("ivec_b1", 1'b0, 1'b0, 32'h0, 16'h0);
      chk("ivec_lo", o_imem_addr, 32'd3);
      tick();
      chk("ivec_run", o_imem_addr, 32'h80);
      tick();
      chk_out("isr_first", 1'b1, 1'b0, 32'h80, 16'hA580);

      i_branch_taken = 1'b1; i_branch_target = 32'h30;
      tick();
      i_branch_taken = 1'b0; i_imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("wait_addr", o_imem_addr, 32'h30);
         chk("wait_valid", {31'd0, o_valid}, 32'd0);
      end
      i_imem_ready = 1'b1;
      tick();
      chk_out("wait_done", 1'b1, 1'b0, 32'h30, 16'hA530);

      imem[0] = 16'hFFFF; imem[1] = 16'hFFFF;
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      tick(); tick();
      chk("wrap_addr", o_imem_addr, 32'hFFFF_FFFF);
      tick();
      chk_out("wrap_last", 1'b1, 1'b0, 32'hFFFF_FFFF, 16'hA5FF);
      chk("wrap_next", o_imem_addr, 32'd0);
      tick();
      chk_out("wrap_zero", 1'b1, 1'b0, 32'h0, 16'hFFFF);

      i_interrupt = 1'b1;
      tick();
      i_interrupt = 1'b0;
      chk_out("pre_tok", 1'b1, 1'b0, 32'h1, 16'hFFFF);
      tick();
      chk_out("tok2", 1'b1, 1'b1, 32'h2, 16'h0000);
      tick();
      chk("intlo_addr", o_imem_addr, 32'd3);
      imem[0] = 16'h0000; imem[1] = 16'h0010;
      i_reset = 1'b0; settle();
      chk("intlo_rst_req", {31'd0, o_imem_req}, 32'd0);
      tick();
      chk_out("intlo_rst", 1'b0, 1'b0, 32'h0, 16'h0);
      chk("intlo_rst_pc", o_pc, 32'd0);
      i_reset = 1'b1; settle();
      chk("re_addr0", o_imem_addr, 32'd0);
      tick();
      chk("re_addr1", o_imem_addr, 32'd1);
      tick();
      chk("re_req", {31'd0, o_imem_req}, 32'd1);
      chk("re_run", o_imem_addr, 32'h10);
      tick();
      chk_out("re_first", 1'b1, 1'b0, 32'h10, 16'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_VEC_ADDR, default 32'h0000_0000, meaning address of the reset-vector high word; the low word is at +1.
REQ-002 SHALL have parameter INT_VEC_ADDR, default 32'h0000_0002, meaning address of the interrupt-vector high word; the low word is at +1.
REQ-003 SHALL have port i_clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port o_imem_req  out  1  instruction-memory read request.
REQ-006 SHALL have port o_imem_addr  out  32  instruction-memory word address.
REQ-007 SHALL have port i_imem_ready  in  1  read completes in a cycle where o_imem_req and i_imem_ready are both 1.
REQ-008 SHALL have port i_imem_data  in  16  read data, valid in the completing cycle.
REQ-009 SHALL have port i_stall  in  1  decode hazard stall; holds the fetch outputs.
REQ-010 SHALL have port i_branch_taken  in  1  redirect request.
REQ-011 SHALL have port i_branch_target  in  32  redirect address.
REQ-012 SHALL have port i_interrupt  in  1  external interrupt request, level-sampled.
REQ-013 SHALL have port o_instr  out  16  instruction to decode.
REQ-014 SHALL have port o_pc  out  32  address of o_instr, or the return address for an interrupt token.
REQ-015 SHALL have port o_valid  out  1  o_instr and o_pc are meaningful.
REQ-016 SHALL have port o_interrupt  out  1  current output is an interrupt token.

Function
REQ-017 SHALL implement states RST_HI, RST_LO, RUN, INT_HI, INT_LO.
REQ-018 SHALL hold o_imem_addr stable while o_imem_req=1 and i_imem_ready=0.
REQ-019 RST_HI: SHALL request RESET_VEC_ADDR, load pc[31:16] on completion, then go to RST_LO. RST_LO: SHALL request RESET_VEC_ADDR+1, load pc[15:0] on completion, then go to RUN.
REQ-020 RUN, no stall, completion: SHALL register o_instr<=data, o_pc<=pc, o_valid<=1, o_interrupt<=0, pc<=pc+1 (modulo 2^32, 32'hFFFF_FFFF wraps to 0).
REQ-021 RUN, no stall, no completion: SHALL register o_valid<=0 (bubble), with pc unchanged.
REQ-022 i_stall=1: SHALL hold o_instr, o_pc, o_valid and o_interrupt; SHALL hold pc; SHALL drive o_imem_req=0; any vector-load progress SHALL pause.
REQ-023 i_branch_taken=1 SHALL take priority over stall, completion and interrupt: pc<=i_branch_target, o_valid<=0, o_interrupt<=0, and a same-cycle completion SHALL be discarded.
REQ-024 SHALL set an interrupt-pending flag whenever i_interrupt=1 is sampled in any state.
REQ-025 In RUN with pending=1, no stall and no branch, SHALL emit a token (o_valid=1, o_interrupt=1, o_instr=16'h0000, o_pc=pc), clear pending, and go to INT_HI without fetching.
REQ-026 INT_HI/INT_LO SHALL load pc from INT_VEC_ADDR / INT_VEC_ADDR+1 exactly as RST_HI/RST_LO do, drive o_valid=0 while not stalled, then return to RUN.
REQ-027 Branch and pending in the same cycle: the branch is taken and pending is retained; the token is issued on a later eligible cycle with o_pc = the branch target.
REQ-028 o_interrupt SHALL be 1 only for the single token output.

Reset
REQ-029 i_reset=0 at a clock edge SHALL force state=RST_HI, pc=0, pending=0, o_valid=0, o_interrupt=0, o_instr=16'h0000, o_pc=0, and drive o_imem_req=0 in that cycle, from any state including mid-vector-load.
REQ-030 After release, the first request SHALL be issued in the first cycle with i_reset=1.

Structure
REQ-031 The shared package SHALL hold the state encoding, the NOP constant 16'h0000, and the default vector addresses.
REQ-032 The design SHALL have one sub-module, pc_register: a 32-bit register with hold, increment, full load and half-word (high/low) load.

Verification
REQ-033 imem[0]=16'h0000, imem[1]=16'h0010, imem[0x10]=16'h1234, ready always 1 -> addresses 0 then 1 are read, and the first o_valid output is o_pc=0x10, o_instr=0x1234.
REQ-034 i_stall=1 for 2 cycles while o_pc=0x11 -> outputs frozen and o_imem_req=0; the next valid output is o_pc=0x12.
REQ-035 i_branch_taken=1 with target 0x40 in the cycle fetching 0x13 -> 0x13 is never valid; the next valid output is o_pc=0x40.
REQ-036 i_interrupt pulse at pc=0x20, imem[2]=0, imem[3]=0x80 -> token o_interrupt=1, o_pc=0x20; then reads of addresses 2 and 3; the next valid output is o_pc=0x80.
REQ-037 i_imem_ready=0 for 3 cycles at address 0x30 -> o_imem_addr stays 0x30, o_valid=0, pc unchanged.
REQ-038 pc=32'hFFFF_FFFF fetch -> the next request is address 0; i_reset=0 during INT_LO -> state RST_HI, pending cleared, then the reset-vector sequence.
